timer_apb_slave: RTL and testbench

APB responder that terminates the CPU register accesses to the 8-bit timer. It decodes TDR (0x00), TCR (0x01) and TSR (0x02), and applies the per-register write masks. It inserts programmable wait states and drives the register fields and flag handling to and from the timer counter core. It sits between the APB bus and the counter/clock-select logic inside the timer top.

---
 rtl/timer_apb_slave.sv | 142 ++++++++++++++
 tb/tb_timer_apb_slave.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_slave.sv
// APB register front-end for the 8-bit timer: TDR/TCR/TSR decode, write masks, wait states, flag capture.
// Optional pslverr reporting is enabled by defining TIMER_APB_PSLVERR_EN; otherwise pslverr stays 0.
module timer_apb_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [7:0]            tdr,
    output logic                  tcr_load,
    output logic                  tcr_updw,
    output logic                  tcr_en,
    output logic [1:0]            tcr_cks,
    input  logic                  ovf_set,
    input  logic                  udf_set,
    output logic                  tsr_ovf,
    output logic                  tsr_udf
);

    // The state runs one cycle ahead of the bus so pready/prdata can be registered:
    // SETUP = wait states being counted, ACCESS = the cycle in which pready is high.
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state;
    logic [3:0]              wcnt;
    logic [7:0]              tdr_q;
    logic [7:0]              tcr_q;
    logic [1:0]              tsr_q;

    logic                    hit_tdr;
    logic                    hit_tcr;
    logic                    hit_tsr;
    logic                    unmapped;
    logic                    err;
    logic                    commit;
    logic [7:0]              rd_val;
    logic [DATA_WIDTH-1:0]   rd_bus;
    logic [1:0]              tsr_nxt;

    always_comb begin
        hit_tdr  = (paddr == ADDR_WIDTH'(0));
        hit_tcr  = (paddr == ADDR_WIDTH'(1));
        hit_tsr  = (paddr == ADDR_WIDTH'(2));
        unmapped = !(hit_tdr || hit_tcr || hit_tsr);
        rd_val   = 8'h00;
        if (hit_tdr)      rd_val = tdr_q;
        else if (hit_tcr) rd_val = tcr_q;
        else if (hit_tsr) rd_val = {6'b0, tsr_q};
        rd_bus   = pwrite ? '0 : DATA_WIDTH'(rd_val);
`ifdef TIMER_APB_PSLVERR_EN
        err      = unmapped || (pwrite && hit_tsr && (pwdata[7:2] != 6'd0));
`else
        err      = 1'b0;
`endif
    end

    assign commit = (state == ACCESS) && psel && penable && pwrite;

    // Hardware set pulses are ORed in after the write-0-to-clear so a same-cycle set wins.
    always_comb begin
        tsr_nxt = tsr_q;
        if (commit && hit_tsr)
            tsr_nxt = tsr_q & pwdata[1:0];
        tsr_nxt = tsr_nxt | {udf_set, ovf_set};
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state   <= IDLE;
            wcnt    <= 4'd0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            tdr_q   <= 8'h00;
            tcr_q   <= 8'h00;
            tsr_q   <= 2'b00;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            tsr_q   <= tsr_nxt;

            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        if (WAIT_CYCLES == 0) begin
                            state   <= ACCESS;
                            pready  <= 1'b1;
                            pslverr <= err;
                            prdata  <= rd_bus;
                        end else begin
                            state <= SETUP;
                            wcnt  <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                SETUP: begin
                    if (!psel) begin
                        state <= IDLE;
                        wcnt  <= 4'd0;
                    end else if (penable) begin
                        if (wcnt == 4'd1) begin
                            state   <= ACCESS;
                            wcnt    <= 4'd0;
                            pready  <= 1'b1;
                            pslverr <= err;
                            prdata  <= rd_bus;
                        end else begin
                            wcnt <= wcnt - 4'd1;
                        end
                    end
                end
                ACCESS: begin
                    state <= IDLE;
                    if (commit) begin
                        if (hit_tdr) tdr_q <= pwdata[7:0];
                        if (hit_tcr) tcr_q <= pwdata[7:0] & 8'hB3;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tdr      = tdr_q;
    assign tcr_load = tcr_q[7];
    assign tcr_updw = tcr_q[5];
    assign tcr_en   = tcr_q[4];
    assign tcr_cks  = tcr_q[1:0];
    assign tsr_ovf  = tsr_q[0];
    assign tsr_udf  = tsr_q[1];

endmodule

// File: tb/tb_timer_apb_slave.sv
// Directed bench for timer_apb_slave: one instance with no wait states, one with three.
// Expected transfer results are queued when a transfer is issued and compared when pready is seen.
module tb_timer_apb_slave;

    logic       pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic       preset, penable, pwrite, psel0, psel3, ovf_set, udf_set;
    logic [7:0] paddr, pwdata;

    logic [7:0] prdata0, tdr0, prdata3, tdr3;
    logic       pready0, pslverr0, tcr_load0, tcr_updw0, tcr_en0, tsr_ovf0, tsr_udf0;
    logic       pready3, pslverr3, tcr_load3, tcr_updw3, tcr_en3, tsr_ovf3, tsr_udf3;
    logic [1:0] tcr_cks0, tcr_cks3;

    timer_apb_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_CYCLES(0)) u0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
        .tdr(tdr0), .tcr_load(tcr_load0), .tcr_updw(tcr_updw0), .tcr_en(tcr_en0),
        .tcr_cks(tcr_cks0), .ovf_set(ovf_set), .udf_set(udf_set),
        .tsr_ovf(tsr_ovf0), .tsr_udf(tsr_udf0)
    );

    timer_apb_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_CYCLES(3)) u3 (
        .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
        .tdr(tdr3), .tcr_load(tcr_load3), .tcr_updw(tcr_updw3), .tcr_en(tcr_en3),
        .tcr_cks(tcr_cks3), .ovf_set(1'b0), .udf_set(1'b0),
        .tsr_ovf(tsr_ovf3), .tsr_udf(tsr_udf3)
    );

    typedef struct {
        logic [7:0] rd;
        logic       err;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cur      = 0;
    logic [7:0] m_tdr, m_tcr, m3_tdr;
    logic [1:0] m_tsr;
    logic       cur_rdy, cur_err;
    logic [7:0] cur_rd;

    always_comb begin
        cur_rdy = (cur == 0) ? pready0  : pready3;
        cur_err = (cur == 0) ? pslverr0 : pslverr3;
        cur_rd  = (cur == 0) ? prdata0  : prdata3;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic exp_err(input logic wr, input logic [7:0] a, input logic [7:0] d);
`ifdef TIMER_APB_PSLVERR_EN
        return (a > 8'h02) || (wr && a == 8'h02 && d[7:2] != 6'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] model_read(input int inst, input logic [7:0] a);
        if (inst == 0) begin
            case (a)
                8'h00:   return m_tdr;
                8'h01:   return m_tcr;
                8'h02:   return {6'b0, m_tsr};
                default: return 8'h00;
            endcase
        end
        return (a == 8'h00) ? m3_tdr : 8'h00;
    endfunction

    task automatic model_write(input int inst, input logic [7:0] a, input logic [7:0] d);
        if (inst == 0) begin
            case (a)
                8'h00:   m_tdr = d;
                8'h01:   m_tcr = d & 8'hB3;
                8'h02:   m_tsr = m_tsr & d[1:0];
                default: ;
            endcase
        end else if (a == 8'h00) begin
            m3_tdr = d;
        end
    endtask

    task automatic xfer(input int inst, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input bit udf_pulse, input string tag);
        exp_t e;
        int   cyc;
        bit   done;
        e.lat = (inst == 0) ? 2 : 5;
        e.rd  = wr ? 8'h00 : model_read(inst, a);
        e.err = exp_err(wr, a, d);
        sb.push_back(e);
        cur = inst;
        @(posedge pclk); #1;
        if (inst == 0) psel0 = 1'b1; else psel3 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        if (udf_pulse) udf_set = 1'b1;
        cyc  = 2;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge pclk);
            if (cur_rdy) begin
                e = sb.pop_front();
                chk({tag, "_prdata"},  cur_rd,  e.rd);
                chk({tag, "_pslverr"}, cur_err, e.err);
                chk({tag, "_latency"}, cyc,     e.lat);
                done = 1'b1;
            end else begin
                cyc++;
            end
        end
        if (!done) begin
            chk({tag, "_timeout"}, cur_rdy, 1);
            void'(sb.pop_front());
        end
        @(posedge pclk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; udf_set = 1'b0;
        if (wr && done) model_write(inst, a, d);
        if (udf_pulse) m_tsr = m_tsr | 2'b10;
    endtask

    task automatic pulse_flag(input bit ovf);
        @(posedge pclk); #1;
        if (ovf) ovf_set = 1'b1; else udf_set = 1'b1;
        @(posedge pclk); #1;
        ovf_set = 1'b0; udf_set = 1'b0;
        m_tsr = m_tsr | (ovf ? 2'b01 : 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; ovf_set = 1'b0; udf_set = 1'b0;
        m_tdr = 8'h00; m_tcr = 8'h00; m3_tdr = 8'h00; m_tsr = 2'b00;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        chk("rst_pready",  {pready0, pready3},   2'b00);
        chk("rst_pslverr", pslverr0,             1'b0);
        chk("rst_prdata",  prdata0,              8'h00);
        chk("rst_tdr",     tdr0,                 8'h00);
        chk("rst_tcr",     {tcr_load0, tcr_updw0, tcr_en0, tcr_cks0}, 5'b0);
        chk("rst_tsr",     {tsr_udf0, tsr_ovf0}, 2'b00);

        xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, "rd_tdr_rst");
        xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, "rd_tcr_rst");
        xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, "rd_tsr_rst");

        xfer(0, 1'b1, 8'h00, 8'hA5, 1'b0, "wr_tdr");
        @(negedge pclk);
        chk("tdr_out", tdr0, m_tdr);
        xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, "rd_tdr");

        xfer(0, 1'b1, 8'h01, 8'hFF, 1'b0, "wr_tcr_ff");
        xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, "rd_tcr_b3");
        chk("tcr_load_set", tcr_load0, m_tcr[7]);
        xfer(0, 1'b1, 8'h01, 8'h13, 1'b0, "wr_tcr_13");
        @(negedge pclk);
        chk("tcr_fields", {tcr_load0, tcr_updw0, tcr_en0, tcr_cks0},
            {m_tcr[7], m_tcr[5], m_tcr[4], m_tcr[1:0]});

        pulse_flag(1'b0);
        @(negedge pclk);
        chk("udf_flag", {tsr_udf0, tsr_ovf0}, m_tsr);
        xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, "rd_tsr_udf");
        xfer(0, 1'b1, 8'h02, 8'h00, 1'b0, "clr_tsr");
        xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, "rd_tsr_clr");
        xfer(0, 1'b1, 8'h02, 8'h00, 1'b1, "clr_vs_set");
        @(negedge pclk);
        chk("set_wins", {tsr_udf0, tsr_ovf0}, m_tsr);
        xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, "rd_tsr_setwin");

        pulse_flag(1'b1);
        pulse_flag(1'b1);
        @(negedge pclk);
        chk("both_flags", {tsr_udf0, tsr_ovf0}, m_tsr);
        xfer(0, 1'b1, 8'h02, 8'h02, 1'b0, "clr_ovf_only");
        @(negedge pclk);
        chk("ovf_cleared", {tsr_udf0, tsr_ovf0}, m_tsr);
        xfer(0, 1'b1, 8'h02, 8'hFE, 1'b0, "wr_tsr_hibits");
        xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, "rd_tsr_hibits");

        xfer(0, 1'b1, 8'h05, 8'h55, 1'b0, "wr_unmapped");
        @(negedge pclk);
        chk("unmapped_regs", {tdr0, tcr_load0, tcr_updw0, tcr_en0, tcr_cks0, tsr_udf0, tsr_ovf0},
            {m_tdr, m_tcr[7], m_tcr[5], m_tcr[4], m_tcr[1:0], m_tsr});
        xfer(0, 1'b0, 8'hFF, 8'h00, 1'b0, "rd_unmapped");
        chk("idle_prdata", prdata0, 8'h00);

        xfer(3, 1'b1, 8'h00, 8'h7E, 1'b0, "ws_wr_tdr");
        @(negedge pclk);
        chk("ws_tdr_out", tdr3, m3_tdr);

        @(posedge pclk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h11;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel3 = 1'b0; penable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            seen = seen | pready3;
        end
        chk("abort_no_pready", seen, 1'b0);
        chk("abort_tdr_kept", tdr3, m3_tdr);
        xfer(3, 1'b0, 8'h00, 8'h00, 1'b0, "ws_rd_tdr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
